// File: rtl/loop_down_counter_if.sv
// rtl/loop_down_counter_if.sv - controller-side bundle for the loadable down counter
interface loop_down_counter_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] load_val;
    logic         en;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    modport master (
        output start, load_val, en, abort,
        input  count, busy, tc, done
    );

    modport slave (
        input  start, load_val, en, abort,
        output count, busy, tc, done
    );
endinterface

// File: rtl/loop_down_counter.sv
// rtl/loop_down_counter.sv - loadable down counter with start/busy/done handshake
// Optional feature macro: LOOP_DOWN_COUNTER_AUTORELOAD_EN (reload on terminal count, stay in RUN)
module loop_down_counter #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    loop_down_counter_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
    logic [N-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.abort) begin
            state_d = S_IDLE;
            count_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        count_d = bus.load_val;
                        busy_d  = 1'b1;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
                        reload_d = bus.load_val;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here; only en moves the count
                    if (bus.en) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            done_d = 1'b1;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
                            count_d = reload_q;
`else
                            state_d = S_DONE;
                            busy_d  = 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tc    = busy_q && (count_q == '0);
endmodule

// File: tb/tb_loop_down_counter.sv
// tb/tb_loop_down_counter.sv - directed self-checking bench for loop_down_counter
module tb_loop_down_counter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    loop_down_counter_if #(.N(8)) bus ();

    loop_down_counter #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int cnt, input int bsy, input int t, input int dn);
        check_eq({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check_eq({tag, ".busy"},  32'(bus.busy),  32'(bsy));
        check_eq({tag, ".tc"},    32'(bus.tc),    32'(t));
        check_eq({tag, ".done"},  32'(bus.done),  32'(dn));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.load_val = 8'd0;
        bus.en    = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b1;
        step();
        expect_out("post_reset", 0, 0, 0, 0);

`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
        bus.load_val = 8'd1; bus.start = 1'b1; bus.en = 1'b1;
        step(); bus.start = 1'b0;
        expect_out("ar.load", 1, 1, 0, 0);
        step(); expect_out("ar.zero0", 0, 1, 1, 0);
        step(); expect_out("ar.reload0", 1, 1, 0, 1);
        step(); expect_out("ar.zero1", 0, 1, 1, 0);
        step(); expect_out("ar.reload1", 1, 1, 0, 1);
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        expect_out("ar.abort", 0, 0, 0, 0);
        step(); expect_out("ar.idle", 0, 0, 0, 0);
`else
        // load 3, en held: 3,2,1,0 then done then idle
        bus.load_val = 8'd3; bus.start = 1'b1; bus.en = 1'b1;
        step(); bus.start = 1'b0;
        expect_out("t1.c3", 3, 1, 0, 0);
        step(); expect_out("t1.c2", 2, 1, 0, 0);
        step(); expect_out("t1.c1", 1, 1, 0, 0);
        step(); expect_out("t1.c0", 0, 1, 1, 0);
        step(); expect_out("t1.done", 0, 0, 0, 1);
        step(); expect_out("t1.idle", 0, 0, 0, 0);

        // load 2, en pattern 1,0,1,0,1
        bus.load_val = 8'd2; bus.start = 1'b1; bus.en = 1'b0;
        step(); bus.start = 1'b0;
        expect_out("t2.c2", 2, 1, 0, 0);
        bus.en = 1'b1; step(); expect_out("t2.c1a", 1, 1, 0, 0);
        bus.en = 1'b0; step(); expect_out("t2.c1b", 1, 1, 0, 0);
        bus.en = 1'b1; step(); expect_out("t2.c0a", 0, 1, 1, 0);
        bus.en = 1'b0; step(); expect_out("t2.c0b", 0, 1, 1, 0);
        bus.en = 1'b1; step(); expect_out("t2.done", 0, 0, 0, 1);
        bus.en = 1'b0; step(); expect_out("t2.idle", 0, 0, 0, 0);

        // load 0: tc on first RUN cycle, then back-to-back restart from DONE
        bus.load_val = 8'd0; bus.start = 1'b1; bus.en = 1'b1;
        step(); bus.start = 1'b0;
        expect_out("t3.c0", 0, 1, 1, 0);
        step(); expect_out("t3.done", 0, 0, 0, 1);
        bus.load_val = 8'd5; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        expect_out("t3.b2b", 5, 1, 0, 0);
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        expect_out("t3.abort", 0, 0, 0, 0);

        // load 9, start held into RUN is ignored, abort beats start at count 4
        bus.load_val = 8'd9; bus.start = 1'b1; bus.en = 1'b1;
        step();
        expect_out("t4.c9", 9, 1, 0, 0);
        step(); bus.start = 1'b0;
        expect_out("t4.ign", 8, 1, 0, 0);
        repeat (4) step();
        expect_out("t4.c4", 4, 1, 0, 0);
        bus.abort = 1'b1; bus.start = 1'b1;
        step(); bus.abort = 1'b0; bus.start = 1'b0;
        expect_out("t4.abort", 0, 0, 0, 0);
        step(); expect_out("t4.idle", 0, 0, 0, 0);

        // asynchronous reset mid-RUN at count 6
        bus.load_val = 8'd9; bus.start = 1'b1; bus.en = 1'b1;
        step(); bus.start = 1'b0;
        repeat (3) step();
        expect_out("t5.c6", 6, 1, 0, 0);
        #2 rst = 1'b0;
        #1 expect_out("t5.async", 0, 0, 0, 0);
        @(negedge clk); rst = 1'b1;
        step(); expect_out("t5.rel0", 0, 0, 0, 0);
        step(); expect_out("t5.rel1", 0, 0, 0, 0);
        bus.load_val = 8'd1; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        expect_out("t5.restart", 1, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
